// File: rtl/das_readout.sv
// Readout stage: on a rising edge of done, fetches four 2-bit samples from the sample memory,
// packs them into a byte and sends it as a UART-style frame. DAS_READOUT_PARITY_EN adds even parity.
module das_readout #(
    parameter int unsigned BIT_CYCLES = 4,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       done,
    input  logic [1:0] mem_data,
    output logic       read,
    output logic [1:0] address,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned BitW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned LatW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [BitW-1:0] BitMax = BitW'(BIT_CYCLES - 1);
    localparam logic [LatW-1:0] LatMax = LatW'(RD_LAT - 1);
`ifdef DAS_READOUT_PARITY_EN
    localparam logic [3:0] LastIdx = 4'd10;
`else
    localparam logic [3:0] LastIdx = 4'd9;
`endif

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StSend} state_e;

    state_e            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [LatW-1:0]   lat_q, lat_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        byte_q, byte_d;
    logic              done_q, done_d;
    logic              read_q, read_d;
    logic [1:0]        address_q, address_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    // Frame bit idx: 0 start, 1..8 data LSB first, then optional parity, then stop.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] data);
        logic b;
        if (idx == 4'd0) begin
            b = 1'b0;
        end else if (idx <= 4'd8) begin
            b = data[3'(idx - 4'd1)];
`ifdef DAS_READOUT_PARITY_EN
        end else if (idx == 4'd9) begin
            b = ^data;
`endif
        end else begin
            b = 1'b1;
        end
        return b;
    endfunction

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        lat_d        = lat_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        byte_d       = byte_q;
        done_d       = done;
        read_d       = 1'b0;
        address_d    = address_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (done && !done_q) begin
                    state_d   = StFetch;
                    busy_d    = 1'b1;
                    k_d       = 2'd0;
                    read_d    = 1'b1;
                    address_d = 2'd0;
                end
            end
            StFetch: begin
                state_d = StWait;
                lat_d   = '0;
            end
            StWait: begin
                if (lat_q == LatMax) begin
                    byte_d[{k_q, 1'b0} +: 2] = mem_data;
                    if (k_q != 2'd3) begin
                        k_d       = k_q + 2'd1;
                        address_d = k_q + 2'd1;
                        read_d    = 1'b1;
                        state_d   = StFetch;
                    end else begin
                        // Start bit begins on the same edge as the last capture.
                        state_d   = StSend;
                        tx_d      = 1'b0;
                        bit_idx_d = 4'd0;
                        bit_cnt_d = '0;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            StSend: begin
                if (bit_cnt_q == BitMax) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == LastIdx) begin
                        state_d      = StIdle;
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        tx_d         = 1'b1;
                        address_d    = 2'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = frame_bit(bit_idx_q + 4'd1, byte_q);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            k_q          <= 2'd0;
            lat_q        <= '0;
            bit_cnt_q    <= '0;
            bit_idx_q    <= 4'd0;
            byte_q       <= 8'd0;
            done_q       <= 1'b0;
            read_q       <= 1'b0;
            address_q    <= 2'd0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            lat_q        <= lat_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_q       <= byte_d;
            done_q       <= done_d;
            read_q       <= read_d;
            address_q    <= address_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign read       = read_q;
    assign address    = address_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
